// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, keyboard command bytes and device responses.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] i_byte);
        return ~^i_byte;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS/2 clock and data pins and flags falling edges of the synced clock.
module ps2_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_clk_fall
);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;

    // Reset to the idle (released, pulled-up) level so reset never fakes an edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign o_clk_sync  = r_clk_sync[SYNC_STAGES-1];
    assign o_data_sync = r_data_sync[SYNC_STAGES-1];
    assign o_clk_fall  = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts a byte out on
// device clock falls and checks the device acknowledge, with an inter-edge timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_error,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_sync;
    logic w_data_sync;
    logic w_clk_fall;

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_ps2_clk  (i_ps2_clk_in),
        .i_ps2_data (i_ps2_data_in),
        .o_clk_sync (w_clk_sync),
        .o_data_sync(w_data_sync),
        .o_clk_fall (w_clk_fall)
    );

    ps2_tx_state_e    r_state;
    logic [8:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_timeout;
    logic             r_ack_ok;
    logic             r_tx_ready;
    logic             r_tx_busy;
    logic             r_tx_done;
    logic             r_tx_error;
    logic             r_clk_oe;
    logic             r_data_oe;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_timeout  <= '0;
            r_ack_ok   <= 1'b0;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
        end else begin
            r_tx_done  <= 1'b0;
            r_tx_error <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Ready rises one cycle after entering IDLE, so it never overlaps done.
                    r_tx_ready <= 1'b1;
                    if (i_tx_valid && r_tx_ready) begin
                        r_shift    <= {odd_parity(i_tx_data), i_tx_data};
                        r_inh_cnt  <= '0;
                        r_clk_oe   <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_state    <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= StReq;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                StReq: begin
                    r_clk_oe  <= 1'b0;
                    r_bit_cnt <= '0;
                    r_timeout <= '0;
                    r_state   <= StSend;
                end
                StSend, StAck, StWaitIdle: begin
                    if (r_state == StWaitIdle && w_clk_sync && w_data_sync) begin
                        r_tx_done  <= 1'b1;
                        r_tx_error <= ~r_ack_ok;
                        r_tx_busy  <= 1'b0;
                        r_state    <= StIdle;
                    end else if (w_clk_fall) begin
                        // A fall wins over a simultaneous timeout.
                        r_timeout <= '0;
                        if (r_state == StSend) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 4'd9) begin
                                r_data_oe <= 1'b0;
                                r_state   <= StAck;
                            end else begin
                                r_data_oe <= ~r_shift[0];
                                r_shift   <= {1'b0, r_shift[8:1]};
                            end
                        end else if (r_state == StAck) begin
                            r_ack_ok <= ~w_data_sync;
                            r_state  <= StWaitIdle;
                        end
                    end else if (r_timeout == TO_LAST) begin
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_tx_done  <= 1'b1;
                        r_tx_error <= 1'b1;
                        r_tx_busy  <= 1'b0;
                        r_state    <= StIdle;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_tx_busy <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    assign o_tx_ready    = r_tx_ready;
    assign o_tx_busy     = r_tx_busy;
    assign o_tx_done     = r_tx_done;
    assign o_tx_error    = r_tx_error;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple keyboard clocking model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam logic [10:0] FRAME_ED = 11'b1_1_1110_1101_0;
    localparam logic [10:0] FRAME_00 = 11'b1_1_0000_0000_0;
    localparam logic [10:0] FRAME_FF = 11'b1_1_1111_1111_0;
    localparam logic [10:0] FRAME_F4 = 11'b1_0_1111_0100_0;
    localparam logic [10:0] FRAME_AA = 11'b1_1_1010_1010_0;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       clk_oe;
    logic       data_oe;
    logic       m_clk_rel;
    logic       m_data_low;
    logic       ps2_clk;
    logic       ps2_data;

    int total = 0;
    int bad   = 0;

    assign ps2_clk  = ~clk_oe & m_clk_rel;
    assign ps2_data = ~data_oe & ~m_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(2000),
        .SYNC_STAGES   (2)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_tx_busy    (tx_busy),
        .o_tx_done    (tx_done),
        .o_tx_error   (tx_error),
        .i_ps2_clk_in (ps2_clk),
        .i_ps2_data_in(ps2_data),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_data_oe(data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Keyboard: waits for the request, clocks 40/40, samples on rising edges.
    // Stops with the clock held low after fall n_falls when n_falls < 11.
    task automatic kbd(input int n_falls, input bit do_ack, output logic [10:0] bits,
                       output bit ok);
        ok   = 1'b0;
        bits = '0;
        for (int i = 0; i < 200; i++) begin
            if (!clk_oe && data_oe) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) return;
        bits[0] = ps2_data;
        for (int k = 1; k <= 11; k++) begin
            repeat (20) tick();
            if (k == 11 && do_ack) m_data_low = 1'b1;
            repeat (20) tick();
            m_clk_rel = 1'b0;
            if (k == n_falls && k < 11) begin
                repeat (10) tick();
                return;
            end
            repeat (40) tick();
            m_clk_rel = 1'b1;
            if (k <= 10) bits[k] = ps2_data;
        end
        if (do_ack) begin
            repeat (20) tick();
            m_data_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int max, output int cycles, output bit got, output bit err);
        cycles = 0;
        got    = 1'b0;
        err    = 1'b0;
        while (cycles < max) begin
            if (tx_done) begin
                got = 1'b1;
                err = tx_error;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit do_ack, output logic [10:0] bits,
                              output bit ok, output bit got, output bit err);
        int cyc;
        start_tx(d);
        kbd(11, do_ack, bits, ok);
        wait_done(300, cyc, got, err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({tx_ready, tx_busy, tx_done, tx_error, clk_oe, data_oe} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_state: got %b want 100000",
                     {tx_ready, tx_busy, tx_done, tx_error, clk_oe, data_oe});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_set_leds();
        int n_inh = 0;
        int n_req = 0;
        int cyc;
        logic [10:0] bits;
        bit ok, got, err;
        start_tx(CMD_SET_LEDS);
        while (clk_oe && !data_oe && n_inh < 100) begin
            n_inh++;
            tick();
        end
        while (clk_oe && data_oe && n_req < 100) begin
            n_req++;
            tick();
        end
        total++;
        if (n_inh !== 20) begin
            bad++;
            $display("FAIL inhibit_len: got %0d want 20", n_inh);
        end
        total++;
        if (n_req !== 1) begin
            bad++;
            $display("FAIL req_len: got %0d want 1", n_req);
        end
        total++;
        if ({clk_oe, data_oe} !== 2'b01) begin
            bad++;
            $display("FAIL clk_release: got %b want 01", {clk_oe, data_oe});
        end
        kbd(11, 1'b1, bits, ok);
        total++;
        if (!ok || bits !== FRAME_ED) begin
            bad++;
            $display("FAIL frame_ed: got %b ok=%0d want %b", bits, ok, FRAME_ED);
        end
        wait_done(300, cyc, got, err);
        total++;
        if ({got, err, tx_ready} !== 3'b100) begin
            bad++;
            $display("FAIL done_ed: got done,err,ready=%b want 100", {got, err, tx_ready});
        end
        tick();
        total++;
        if ({tx_ready, tx_done} !== 2'b10) begin
            bad++;
            $display("FAIL ready_after_done: got ready,done=%b want 10", {tx_ready, tx_done});
        end
    endtask

    task automatic test_parity();
        logic [7:0]  vals [2] = '{8'h00, 8'hFF};
        logic [10:0] exp  [2] = '{FRAME_00, FRAME_FF};
        logic [10:0] bits;
        bit ok, got, err;
        for (int i = 0; i < 2; i++) begin
            tick();
            send_frame(vals[i], 1'b1, bits, ok, got, err);
            total++;
            if (bits[9] !== 1'b1) begin
                bad++;
                $display("FAIL parity_%02h: got %b want 1", vals[i], bits[9]);
            end
            total++;
            if (bits[8:1] !== vals[i] || bits !== exp[i]) begin
                bad++;
                $display("FAIL frame_%02h: got %b want %b", vals[i], bits, exp[i]);
            end
            total++;
            if ({got, err} !== 2'b10) begin
                bad++;
                $display("FAIL done_%02h: got done,err=%b want 10", vals[i], {got, err});
            end
            tick();
        end
    endtask

    task automatic test_no_ack();
        logic [10:0] bits;
        bit ok, got, err;
        tick();
        send_frame(CMD_ENABLE, 1'b0, bits, ok, got, err);
        total++;
        if ({got, err} !== 2'b11) begin
            bad++;
            $display("FAIL no_ack_done: got done,err=%b want 11", {got, err});
        end
        total++;
        if ({clk_oe, data_oe} !== 2'b00 || bits !== FRAME_F4) begin
            bad++;
            $display("FAIL no_ack_lines: got oe=%b frame=%b want 00 %b",
                     {clk_oe, data_oe}, bits, FRAME_F4);
        end
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        int n = 0;
        logic [10:0] bits;
        bit ok, got, err;
        tick();
        start_tx(CMD_RESET);
        while (!(!clk_oe && data_oe) && n < 100) begin
            n++;
            tick();
        end
        wait_done(2100, cyc, got, err);
        total++;
        if ({got, err, clk_oe, data_oe} !== 4'b1100) begin
            bad++;
            $display("FAIL timeout_done: got done,err,oe=%b want 1100",
                     {got, err, clk_oe, data_oe});
        end
        total++;
        if (cyc !== 2000) begin
            bad++;
            $display("FAIL timeout_len: got %0d want 2000", cyc);
        end
        tick();
        send_frame(CMD_ENABLE, 1'b1, bits, ok, got, err);
        total++;
        if (!ok || bits !== FRAME_F4 || {got, err} !== 2'b10) begin
            bad++;
            $display("FAIL after_timeout: got frame=%b done,err=%b want %b 10",
                     bits, {got, err}, FRAME_F4);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [10:0] bits;
        bit ok;
        tick();
        start_tx(CMD_SET_LEDS);
        kbd(5, 1'b1, bits, ok);
        // Fall 5 drives data bit 4 of 0xED, which is 0.
        total++;
        if (!ok || data_oe !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit4: got data_oe=%b ok=%0d want 1", data_oe, ok);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({clk_oe, data_oe, tx_done, tx_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL mid_reset: got oe,done,ready=%b want 0001",
                     {clk_oe, data_oe, tx_done, tx_ready});
        end
        rst       = 1'b0;
        m_clk_rel = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_done) dones++;
            tick();
        end
        total++;
        if (dones !== 0 || {tx_ready, tx_busy} !== 2'b10) begin
            bad++;
            $display("FAIL mid_after: got dones=%0d ready,busy=%b want 0 10",
                     dones, {tx_ready, tx_busy});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [10:0] bits;
        bit ok, got, err;
        tick();
        tx_data  = CMD_SET_LEDS;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hAA;
        kbd(11, 1'b1, bits, ok);
        total++;
        if (!ok || bits !== FRAME_ED) begin
            bad++;
            $display("FAIL b2b_first: got %b want %b", bits, FRAME_ED);
        end
        wait_done(300, cyc, got, err);
        total++;
        if ({got, err, tx_ready} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_done: got done,err,ready=%b want 100", {got, err, tx_ready});
        end
        tick();
        total++;
        if ({tx_ready, tx_busy} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_ready: got ready,busy=%b want 10", {tx_ready, tx_busy});
        end
        tick();
        tx_valid = 1'b0;
        total++;
        if ({tx_ready, tx_busy, clk_oe} !== 3'b011) begin
            bad++;
            $display("FAIL b2b_accept: got ready,busy,clk_oe=%b want 011",
                     {tx_ready, tx_busy, clk_oe});
        end
        kbd(11, 1'b1, bits, ok);
        wait_done(300, cyc, got, err);
        total++;
        if (!ok || bits !== FRAME_AA || {got, err} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_second: got frame=%b done,err=%b want %b 10",
                     bits, {got, err}, FRAME_AA);
        end
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        m_clk_rel  = 1'b1;
        m_data_low = 1'b0;
        test_reset();
        test_set_leds();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
